alu_op_sequencer: RTL and testbench

Front-panel controller for the ALU datapath. Synchronizes and debounces the five operation buttons plus a dedicated GO button. Sequences a three-press operand/operation entry (load A, load B + execute, show) and drives the ALU operand, opcode and shift-amount inputs. It sits between the board I/O and the ALU: it consumes the ALU result after a fixed latency and presents a registered result with a valid flag.

---
 rtl/alu_op_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: front-panel controller for the ALU datapath.
// Synchronizes and debounces six buttons, turns GO into a single-cycle step
// pulse, and walks a LOAD_A -> LOAD_B -> EXEC -> SHOW entry sequence that
// drives the ALU operands/opcode and captures its result after a fixed latency.
module alu_op_sequencer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ALU_LATENCY     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btnL,
  input  logic             btnC,
  input  logic             btnR,
  input  logic             btnU,
  input  logic             btnD,
  input  logic             btnGo,
  input  logic [WIDTH-1:0] sw,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       ALUControl,
  output logic [1:0]       Cantidad,
  output logic             alu_start,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       phase
);

  // Button index map: 0=L 1=C 2=R 3=U 4=D 5=GO
  localparam int NBTN   = 6;
  localparam int BTN_GO = 5;
  localparam int DCW    = $clog2(DEBOUNCE_CYCLES);
  localparam int LCW    = $clog2(ALU_LATENCY + 1);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'b00,
    S_LOAD_B = 2'b01,
    S_EXEC   = 2'b10,
    S_SHOW   = 2'b11
  } state_t;

  logic [NBTN-1:0] raw_w;
  logic [NBTN-1:0] stable_w;

  assign raw_w = {btnGo, btnD, btnU, btnR, btnC, btnL};

  // One synchronizer + debouncer per button
  for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
    logic           sync1_q;
    logic           sync2_q;
    logic           stable_q;
    logic           stable_d;
    logic [DCW-1:0] cnt_q;
    logic [DCW-1:0] cnt_d;

    // Counter runs while the synchronized value disagrees; accept after a full window
    always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
        if (cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d = sync2_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + DCW'(1);
        end
      end
    end

    // Two-flop synchronizer and debounce state registers
    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q  <= 1'b0;
        sync2_q  <= 1'b0;
        stable_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        sync1_q  <= raw_w[gi];
        sync2_q  <= sync1_q;
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign stable_w[gi] = stable_q;
  end

  logic go_prev_q;
  logic go_pulse;

  // Previous debounced GO value for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      go_prev_q <= 1'b0;
    end else begin
      go_prev_q <= stable_w[BTN_GO];
    end
  end

  // Only the press edge steps the FSM; a release never does
  assign go_pulse = stable_w[BTN_GO] & ~go_prev_q;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [1:0]       cant_q;
  logic             start_q;
  logic [WIDTH-1:0] res_q;
  logic             valid_q;
  logic [LCW-1:0]   lat_q;

  // Entry sequencer; every output is a register written only at its transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cant_q  <= '0;
      start_q <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      case (state_q)
        S_LOAD_A: begin
          if (go_pulse) begin
            a_q     <= sw;
            valid_q <= 1'b0;
            state_q <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (go_pulse) begin
            b_q     <= sw;
            op_q    <= {stable_w[0], stable_w[1], stable_w[2]};
            cant_q  <= {stable_w[3], stable_w[4]};
            start_q <= 1'b1;
            lat_q   <= LCW'(ALU_LATENCY);
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // GO is deliberately ignored here so a press cannot be queued
          start_q <= 1'b0;
          lat_q   <= lat_q - LCW'(1);
          if (lat_q == LCW'(1)) begin
            res_q   <= alu_result;
            valid_q <= 1'b1;
            state_q <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (go_pulse) begin
            valid_q <= 1'b0;
            state_q <= S_LOAD_A;
          end
        end
        default: state_q <= S_LOAD_A;
      endcase
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign ALUControl   = op_q;
  assign Cantidad     = cant_q;
  assign alu_start    = start_q;
  assign result       = res_q;
  assign result_valid = valid_q;
  assign phase        = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer with a small ALU model in the loop.
// Tracks the expected front-panel state per GO press and checks every output.
module tb_alu_op_sequencer;

  localparam int W   = 8;
  localparam int DB  = 4;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         btnL = 1'b0, btnC = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0;
  logic         btnGo = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] alu_result = '0;
  logic [W-1:0] alu_a, alu_b, result;
  logic [2:0]   ALUControl;
  logic [1:0]   Cantidad;
  logic         alu_start, result_valid;
  logic [1:0]   phase;

  int total = 0;
  int bad   = 0;

  // Expected panel state
  int           m_phase;
  logic [W-1:0] m_a, m_b, m_res;
  logic [2:0]   m_op;
  logic [1:0]   m_cant;
  logic         m_valid;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DB), .ALU_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .btnL(btnL), .btnC(btnC), .btnR(btnR), .btnU(btnU), .btnD(btnD),
    .btnGo(btnGo), .sw(sw), .alu_result(alu_result),
    .alu_a(alu_a), .alu_b(alu_b), .ALUControl(ALUControl), .Cantidad(Cantidad),
    .alu_start(alu_start), .result(result), .result_valid(result_valid),
    .phase(phase)
  );

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op, input logic [1:0] c);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << c;
      3'd6:    return a >> c;
      default: return b;
    endcase
  endfunction

  // ALU with a registered output: valid one edge after operands settle,
  // so the sequencer sees it on the second edge after alu_start rises
  always @(posedge clk) alu_result <= alu_f(alu_a, alu_b, ALUControl, Cantidad);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_a = '0; m_b = '0; m_res = '0;
    m_op = '0; m_cant = '0; m_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".phase"}, 32'(phase), 32'(m_phase));
    chk({tag, ".alu_a"}, 32'(alu_a), 32'(m_a));
    chk({tag, ".alu_b"}, 32'(alu_b), 32'(m_b));
    chk({tag, ".op"}, 32'(ALUControl), 32'(m_op));
    chk({tag, ".cant"}, 32'(Cantidad), 32'(m_cant));
    chk({tag, ".start"}, 32'(alu_start), 32'(0));
    chk({tag, ".result"}, 32'(result), 32'(m_res));
    chk({tag, ".valid"}, 32'(result_valid), 32'(m_valid));
    $display("txn %s: phase=%0d a=%02h b=%02h op=%0d cant=%0d result=%02h valid=%0b",
             tag, phase, alu_a, alu_b, ALUControl, Cantidad, result, result_valid);
  endtask

  // One GO press (10 edges held, 8 released); if freeze, disturb sw and btnL on EXEC entry
  task automatic press(input string tag, input bit freeze);
    int           old;
    int           ep;
    logic [W-1:0] cap_sw;
    logic [2:0]   cap_op;
    logic [1:0]   cap_c;
    old    = m_phase;
    cap_sw = sw;
    cap_op = {btnL, btnC, btnR};
    cap_c  = {btnU, btnD};
    btnGo  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k < DB + 3)   ep = old;
      else if (old == 1) ep = (k < DB + 3 + LAT) ? 2 : 3;
      else              ep = (old + 1) % 4;
      chk({tag, ".step_phase"}, 32'(phase), 32'(ep));
      chk({tag, ".step_start"}, 32'(alu_start), 32'((old == 1 && k == DB + 3) ? 1 : 0));
      if (freeze && k == DB + 3) begin
        sw   = ~sw;
        btnL = ~btnL;
      end
    end
    btnGo = 1'b0;
    repeat (8) tick();
    case (old)
      0: begin m_a = cap_sw; m_valid = 1'b0; m_phase = 1; end
      1: begin
        m_b = cap_sw; m_op = cap_op; m_cant = cap_c;
        m_res = alu_f(m_a, cap_sw, cap_op, cap_c);
        m_valid = 1'b1; m_phase = 3;
      end
      default: begin m_valid = 1'b0; m_phase = 0; end
    endcase
    check_all(tag);
  endtask

  task automatic set_buttons(input logic [2:0] op, input logic [1:0] c);
    {btnL, btnC, btnR} = op;
    {btnU, btnD} = c;
    repeat (8) tick();
  endtask

  initial begin
    model_reset();

    // Reset
    reset = 1'b1;
    tick();
    check_all("reset");
    reset = 1'b0;
    repeat (3) tick();

    // Debounce latency: step exactly at edge DB+3 and only once
    btnGo = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("deb.edge%0d", k), 32'(phase), 32'((k >= DB + 3) ? 1 : 0));
    end
    btnGo = 1'b0;
    repeat (10) tick();
    chk("deb.release", 32'(phase), 32'(1));
    // Short glitch must not step
    btnGo = 1'b1;
    repeat (3) tick();
    btnGo = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("deb.glitch", 32'(phase), 32'(1));
    end
    $display("txn debounce: phase=%0d", phase);

    // Back to a clean start
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_all("reset2");

    // Full add sequence
    sw = 8'h25;
    press("add.loadA", 1'b0);
    sw = 8'h11;
    set_buttons(3'b000, 2'b10);
    press("add.exec", 1'b0);
    chk("add.result", 32'(result), 32'h36);

    // Wrap-around keeps result, then 0xFF into alu_a
    press("wrap", 1'b0);
    sw = 8'hFF;
    press("wrap.loadFF", 1'b0);

    // Freeze: disturb inputs as EXEC starts, GO still held
    sw = 8'h3C;
    set_buttons(3'b001, 2'b01);
    press("freeze", 1'b1);
    repeat (10) tick();
    check_all("freeze.hold");
    press("freeze.wrap", 1'b0);

    // Randomized operations
    for (int i = 0; i < 6; i++) begin
      sw = W'($urandom);
      press($sformatf("rnd%0d.A", i), 1'b0);
      sw = W'($urandom);
      set_buttons(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      press($sformatf("rnd%0d.X", i), 1'b0);
      press($sformatf("rnd%0d.W", i), 1'b0);
    end

    // Reset mid-EXEC discards the operation
    sw = 8'h5A;
    press("midrst.A", 1'b0);
    sw = 8'h66;
    set_buttons(3'b000, 2'b11);
    btnGo = 1'b1;
    repeat (DB + 3) tick();
    chk("midrst.start", 32'(alu_start), 32'(1));
    chk("midrst.phase", 32'(phase), 32'(2));
    reset = 1'b1;
    btnGo = 1'b0;
    tick();
    model_reset();
    check_all("midrst.now");
    reset = 1'b0;
    repeat (6) tick();
    check_all("midrst.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
